// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions for the fetch-address generator:
// reset vector, fetch FSM states and redirect-source encoding.
package cpu_pkg;

   localparam logic [31:0] CPU_RESET_VECTOR = 32'hbfc00000;

   typedef enum logic [1:0] {
      PCF_IDLE = 2'd0,
      PCF_REQ  = 2'd1,
      PCF_HOLD = 2'd2
   } pcf_state_e;

   // Which source supplies the redirect target this cycle.
   typedef enum logic [1:0] {
      RSEL_NONE = 2'd0,
      RSEL_PEND = 2'd1,
      RSEL_BR   = 2'd2,
      RSEL_EXC  = 2'd3
   } redir_sel_e;

endpackage

// File: rtl/pc_fetch_gen_if.sv
// Instruction request/accept handshake between the fetch-address
// generator (master) and the SRAM-like instruction port (slave).
interface pc_fetch_gen_if #(
   parameter int N = 32
);
   logic         inst_req;
   logic [N-1:0] inst_addr;
   logic         inst_addr_ok;

   modport master (
      output inst_req,
      output inst_addr,
      input  inst_addr_ok
   );

   modport slave (
      input  inst_req,
      input  inst_addr,
      output inst_addr_ok
   );
endinterface

// File: rtl/pc_redirect_latch.sv
// Pending-redirect register plus the combinational redirect-target select.
// A pending flush is never displaced by a later branch.
module pc_redirect_latch
   import cpu_pkg::*;
#(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         capture,
   input  logic         clear,
   input  logic         flush_except,
   input  logic [N-1:0] except_pc,
   input  logic         br_taken,
   input  logic [N-1:0] br_target,
   output logic         redir_v,
   output logic [N-1:0] redir_t
);

   logic         pend_v_q,   pend_v_d;
   logic         pend_exc_q, pend_exc_d;
   logic [N-1:0] pend_t_q,   pend_t_d;
   redir_sel_e   sel;

   always_ff @(posedge clk) begin
      if (rst) begin
         pend_v_q   <= 1'b0;
         pend_exc_q <= 1'b0;
         pend_t_q   <= '0;
      end else begin
         pend_v_q   <= pend_v_d;
         pend_exc_q <= pend_exc_d;
         pend_t_q   <= pend_t_d;
      end
   end

   always_comb begin
      pend_v_d   = pend_v_q;
      pend_exc_d = pend_exc_q;
      pend_t_d   = pend_t_q;
      if (clear) begin
         pend_v_d   = 1'b0;
         pend_exc_d = 1'b0;
      end else if (capture) begin
         if (flush_except) begin
            pend_v_d   = 1'b1;
            pend_exc_d = 1'b1;
            pend_t_d   = except_pc;
         end else if (br_taken && !(pend_v_q && pend_exc_q)) begin
            pend_v_d   = 1'b1;
            pend_exc_d = 1'b0;
            pend_t_d   = br_target;
         end
      end
   end

   always_comb begin
      if (flush_except)  sel = RSEL_EXC;
      else if (br_taken) sel = RSEL_BR;
      else if (pend_v_q) sel = RSEL_PEND;
      else               sel = RSEL_NONE;
   end

   always_comb begin
      redir_v = (sel != RSEL_NONE);
      case (sel)
         RSEL_EXC:  redir_t = except_pc;
         RSEL_BR:   redir_t = br_target;
         RSEL_PEND: redir_t = pend_t_q;
         default:   redir_t = pend_t_q;
      endcase
   end

endmodule

// File: rtl/pc_fetch_gen.sv
// IF-stage fetch-address generator: owns the PC, issues instruction
// requests and records the last accepted fetch for IF/ID.
module pc_fetch_gen
   import cpu_pkg::*;
#(
   parameter int          N            = 32,
   parameter int          STEP         = 4,
   parameter logic [N-1:0] RESET_VECTOR = N'(CPU_RESET_VECTOR),
   parameter int          ALIGN_BITS   = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 flush_except,
   input  logic [N-1:0]         except_pc,
   input  logic                 br_taken,
   input  logic [N-1:0]         br_target,
   pc_fetch_gen_if.master       bus,
   output logic [N-1:0]         pc,
   output logic [N-1:0]         fetch_pc,
   output logic                 fetch_valid,
   output logic                 fetch_adel
);

   localparam logic [N-1:0] ALIGN_MASK = N'((64'd1 << ALIGN_BITS) - 64'd1);

   pcf_state_e   state_q, state_d;
   logic [N-1:0] pc_q, pc_d;
   logic [N-1:0] fetch_pc_q, fetch_pc_d;
   logic         fetch_valid_q, fetch_valid_d;
   logic         fetch_adel_q, fetch_adel_d;

   logic         misaligned;
   logic         accept;
   logic         in_req;
   logic         redir_v;
   logic [N-1:0] redir_t;

   assign misaligned = |(pc_q & ALIGN_MASK);
   assign in_req     = (state_q == PCF_REQ);
   // A misaligned PC is never issued, so it counts as accepted on its own.
   assign accept     = in_req && (bus.inst_addr_ok || misaligned);

   pc_redirect_latch #(.N(N)) u_redirect (
      .clk          (clk),
      .rst          (rst),
      .capture      (in_req && !accept),
      .clear        (accept),
      .flush_except (flush_except),
      .except_pc    (except_pc),
      .br_taken     (br_taken),
      .br_target    (br_target),
      .redir_v      (redir_v),
      .redir_t      (redir_t)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= PCF_IDLE;
         pc_q          <= RESET_VECTOR;
         fetch_pc_q    <= RESET_VECTOR;
         fetch_valid_q <= 1'b0;
         fetch_adel_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         fetch_pc_q    <= fetch_pc_d;
         fetch_valid_q <= fetch_valid_d;
         fetch_adel_q  <= fetch_adel_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      fetch_pc_d    = fetch_pc_q;
      fetch_valid_d = fetch_valid_q;
      fetch_adel_d  = fetch_adel_q;
      case (state_q)
         PCF_IDLE: state_d = PCF_REQ;
         PCF_REQ: begin
            if (accept) begin
               fetch_pc_d   = pc_q;
               fetch_adel_d = misaligned;
               if (redir_v) begin
                  pc_d          = redir_t;
                  fetch_valid_d = 1'b0;
               end else if (en) begin
                  pc_d          = pc_q + N'(STEP);
                  fetch_valid_d = 1'b1;
               end else begin
                  state_d       = PCF_HOLD;
                  fetch_valid_d = 1'b1;
               end
            end
         end
         PCF_HOLD: begin
            if (redir_v) begin
               pc_d    = redir_t;
               state_d = PCF_REQ;
            end else if (en) begin
               pc_d    = pc_q + N'(STEP);
               state_d = PCF_REQ;
            end
         end
         default: state_d = PCF_IDLE;
      endcase
   end

   always_comb begin
      bus.inst_req  = in_req && !misaligned;
      bus.inst_addr = pc_q;
      pc            = pc_q;
      fetch_pc      = fetch_pc_q;
      fetch_valid   = fetch_valid_q;
      fetch_adel    = fetch_adel_q;
   end

endmodule

// File: tb/tb_pc_fetch_gen.sv
// Directed bench for pc_fetch_gen: inputs change and outputs are checked
// on the falling edge, so every check sees the state after the last rising edge.
module tb_pc_fetch_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        flush_except;
   logic [31:0] except_pc;
   logic        br_taken;
   logic [31:0] br_target;
   logic [31:0] pc;
   logic [31:0] fetch_pc;
   logic        fetch_valid;
   logic        fetch_adel;

   int checks_cnt   = 0;
   int failures_cnt = 0;

   pc_fetch_gen_if #(.N(32)) ibus ();

   pc_fetch_gen #(
      .N            (32),
      .STEP         (4),
      .RESET_VECTOR (32'hbfc00000),
      .ALIGN_BITS   (2)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .flush_except (flush_except),
      .except_pc    (except_pc),
      .br_taken     (br_taken),
      .br_target    (br_target),
      .bus          (ibus.master),
      .pc           (pc),
      .fetch_pc     (fetch_pc),
      .fetch_valid  (fetch_valid),
      .fetch_adel   (fetch_adel)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks_cnt++;
      if (got !== exp) begin
         failures_cnt++;
         $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_req(input string tag, input logic req, input logic [31:0] addr);
      check_val({tag, ".req"}, {31'd0, ibus.inst_req}, {31'd0, req});
      if (req) check_val({tag, ".addr"}, ibus.inst_addr, addr);
      $display("txn %s: inst_req=%0d inst_addr=%08h pc=%08h fetch_pc=%08h valid=%0d adel=%0d",
               tag, ibus.inst_req, ibus.inst_addr, pc, fetch_pc, fetch_valid, fetch_adel);
   endtask

   task automatic check_fetch(input string tag, input logic [31:0] fpc, input logic fv, input logic fa);
      check_val({tag, ".fetch_pc"}, fetch_pc, fpc);
      check_val({tag, ".fetch_valid"}, {31'd0, fetch_valid}, {31'd0, fv});
      check_val({tag, ".fetch_adel"}, {31'd0, fetch_adel}, {31'd0, fa});
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      check_req("reset", 1'b0, 32'h0);
      check_val("reset.pc", pc, 32'hbfc00000);
      check_fetch("reset", 32'hbfc00000, 1'b0, 1'b0);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; flush_except = 1'b0; except_pc = '0;
      br_taken = 1'b0; br_target = '0; ibus.inst_addr_ok = 1'b0;
      @(negedge clk);

      // Back-to-back sequential fetch
      do_reset();
      en = 1'b1; ibus.inst_addr_ok = 1'b1;
      tick(); check_req("b2b0", 1'b1, 32'hbfc00000);
      check_val("b2b0.valid", {31'd0, fetch_valid}, 32'd0);
      tick(); check_req("b2b1", 1'b1, 32'hbfc00004);
      check_fetch("b2b1", 32'hbfc00000, 1'b1, 1'b0);
      tick(); check_req("b2b2", 1'b1, 32'hbfc00008);

      // Stall into HOLD after accepting 0xbfc00004
      do_reset();
      en = 1'b1; ibus.inst_addr_ok = 1'b1;
      tick(); tick(); check_req("hold_pre", 1'b1, 32'hbfc00004);
      en = 1'b0;
      tick(); check_req("hold0", 1'b0, 32'h0);
      check_val("hold0.pc", pc, 32'hbfc00004);
      check_fetch("hold0", 32'hbfc00004, 1'b1, 1'b0);
      tick(); check_req("hold1", 1'b0, 32'h0);
      check_val("hold1.pc", pc, 32'hbfc00004);
      en = 1'b1;
      tick(); check_req("hold_exit", 1'b1, 32'hbfc00008);

      // Branch captured while 0xbfc00010 is outstanding
      tick(); tick(); check_req("br_pre", 1'b1, 32'hbfc00010);
      ibus.inst_addr_ok = 1'b0; br_taken = 1'b1; br_target = 32'h80001000;
      tick(); check_req("br_stall0", 1'b1, 32'hbfc00010);
      br_taken = 1'b0; br_target = 32'h0;
      tick(); check_req("br_stall1", 1'b1, 32'hbfc00010);
      ibus.inst_addr_ok = 1'b1;
      tick(); check_req("br_taken", 1'b1, 32'h80001000);
      check_fetch("br_taken", 32'hbfc00010, 1'b0, 1'b0);

      // Pending branch replaced by a flush; simultaneous branch ignored
      tick(); check_req("fl_pre", 1'b1, 32'h80001004);
      ibus.inst_addr_ok = 1'b0; br_taken = 1'b1; br_target = 32'h80001000;
      tick();
      flush_except = 1'b1; except_pc = 32'hbfc00380; br_target = 32'h80005000;
      tick(); check_req("fl_stall", 1'b1, 32'h80001004);
      flush_except = 1'b0; br_taken = 1'b0; ibus.inst_addr_ok = 1'b1;
      tick(); check_req("fl_taken", 1'b1, 32'hbfc00380);
      check_fetch("fl_taken", 32'h80001004, 1'b0, 1'b0);

      // Misaligned branch target raises fetch_adel, flush recovers
      br_taken = 1'b1; br_target = 32'h80000002;
      tick(); br_taken = 1'b0;
      check_req("adel0", 1'b0, 32'h0);
      check_val("adel0.pc", pc, 32'h80000002);
      tick(); check_req("adel1", 1'b0, 32'h0);
      check_fetch("adel1", 32'h80000002, 1'b1, 1'b1);
      flush_except = 1'b1; except_pc = 32'hbfc00380;
      tick(); flush_except = 1'b0;
      check_req("adel_fl", 1'b1, 32'hbfc00380);
      check_fetch("adel_fl", 32'h80000006, 1'b0, 1'b1);
      tick(); check_req("adel_ok", 1'b1, 32'hbfc00384);
      check_fetch("adel_ok", 32'hbfc00380, 1'b1, 1'b0);

      // Wrap at top of address space
      flush_except = 1'b1; except_pc = 32'hfffffffc;
      tick(); flush_except = 1'b0;
      check_req("wrap0", 1'b1, 32'hfffffffc);
      tick(); check_req("wrap1", 1'b1, 32'h00000000);

      // Reset with a request outstanding and a branch pending
      ibus.inst_addr_ok = 1'b0; br_taken = 1'b1; br_target = 32'h80001000;
      tick(); br_taken = 1'b0;
      rst = 1'b1;
      tick(); check_req("rst_mid", 1'b0, 32'h0);
      check_val("rst_mid.pc", pc, 32'hbfc00000);
      check_fetch("rst_mid", 32'hbfc00000, 1'b0, 1'b0);
      rst = 1'b0;
      tick(); check_req("rst_req", 1'b1, 32'hbfc00000);
      ibus.inst_addr_ok = 1'b1;
      tick(); check_req("rst_nopend", 1'b1, 32'hbfc00004);
      check_fetch("rst_nopend", 32'hbfc00000, 1'b1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, failures_cnt);
      $finish;
   end

endmodule

// File: doc/pc_fetch_gen.md
# pc_fetch_gen

Parametrised fetch-address generator for the IF stage: holds the program counter and drives an SRAM-like instruction request/accept handshake. Selects next PC from exception flush, branch redirect and sequential increment, with stall support. Captures redirects that arrive while a request is outstanding, and marks superseded fetches invalid. Sits between the CP0/branch logic and the instruction SRAM-like port, and feeds IF/ID.

## Interface
- `N`, 32, address width
- `STEP`, 4, sequential increment in bytes
- `RESET_VECTOR`, 32'hbfc00000, PC after reset
- `ALIGN_BITS`, 2, low PC bits that must be zero
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `en`  in  1  pipeline advance (IF/ID not stalled)
- `flush_except`  in  1  exception/eret redirect, highest priority
- `except_pc`  in  N  target for `flush_except`
- `br_taken`  in  1  branch/jump redirect
- `br_target`  in  N  target for `br_taken`
- `inst_req`  out  1  request valid
- `inst_addr`  out  N  request address (= `pc`)
- `inst_addr_ok`  in  1  request accepted this cycle
- `pc`  out  N  current PC
- `fetch_pc`  out  N  PC of last accepted fetch
- `fetch_valid`  out  1  last accepted fetch is architecturally live
- `fetch_adel`  out  1  last fetch address misaligned

## Operation
- States: IDLE, REQ, HOLD. `inst_req` = (state==REQ) && PC aligned.
- IDLE → REQ unconditionally.
- Redirect target: `except_pc` if `flush_except`, else `br_target` if `br_taken`, else pending target.
- Pending latch (`pend_v`, `pend_t`): a redirect in REQ without `inst_addr_ok` is stored. `flush_except` overwrites a pending branch. A branch never overwrites a pending flush. `inst_addr` stays stable until accepted.
- REQ with `inst_addr_ok`:
  - Redirect (this cycle or pending) → `pc`←target, clear pending, stay REQ, capture fetch with `fetch_valid`=0.
  - Else `en` → `pc`←`pc`+STEP, stay REQ, `fetch_valid`=1.
  - Else → HOLD, `fetch_valid`=1.
- HOLD:
  - Redirect → `pc`←target, REQ.
  - Else `en` → `pc`←`pc`+STEP, REQ.
  - Else stay.
- Misaligned PC (`pc[ALIGN_BITS-1:0]`≠0) in REQ:
  - Not issued; treated as accepted that cycle.
  - `fetch_adel`=1, `fetch_valid`=1 unless redirected.
- Increment wraps modulo 2^N.
- Every acceptance loads `fetch_pc`←`pc`.

## Timing
- Reset values: state IDLE, `pc`=RESET_VECTOR, `inst_req`=0, `fetch_pc`=RESET_VECTOR, `fetch_valid`=0, `fetch_adel`=0, pending cleared.
- First request at RESET_VECTOR is 1 cycle after `rst` deasserts (IDLE cycle).
- All state, `pc` and `fetch_*` outputs are registered. `inst_req`/`inst_addr` are decoded from registers only, with no combinational path from inputs.
- Back-to-back: with `en`=1 and `inst_addr_ok`=1 every cycle, one new address per cycle.
- Redirect-to-request latency: 1 cycle in HOLD or when accepted the same cycle. Otherwise 1 cycle after acceptance.
- `rst` mid-request: abandons the request immediately, with no pending state kept.

## Structure
- Shared `cpu_pkg` holds:
  - RESET_VECTOR default
  - state enum (`PCF_IDLE`, `PCF_REQ`, `PCF_HOLD`)
  - redirect-select encoding
- One sub-module, `pc_redirect_latch`: pending valid/target register with flush-over-branch priority, and the combinational target select.

## Test plan
- Reset then `inst_addr_ok`=1, `en`=1 constant → `inst_addr` 0xbfc00000, 0xbfc00004, 0xbfc00008 on consecutive cycles; `fetch_valid`=1 from the cycle after the first accept.
- `en`=0 after accept of 0xbfc00004 → state HOLD, `inst_req`=0, `pc` holds 0xbfc00004 until `en`=1, then request 0xbfc00008.
- `br_taken`=1, `br_target`=0x80001000 while request 0xbfc00010 is pending (`inst_addr_ok`=0) → `inst_addr` stays 0xbfc00010. On accept, `fetch_valid`=0; next request 0x80001000.
- Pending branch 0x80001000 then `flush_except`, `except_pc`=0xbfc00380 before accept → next request 0xbfc00380. A simultaneous `br_taken` with flush is ignored.
- `br_target`=0x80000002 → no `inst_req`; `fetch_pc`=0x80000002 with `fetch_adel`=1 next cycle; a subsequent flush to 0xbfc00380 resumes normal fetch.
- Start at `pc`=0xfffffffc via `except_pc`, `en`=1 → next request 0x00000000 (wrap). Assert `rst` mid-request → `inst_req`=0 next cycle, `pc`=0xbfc00000.
